// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program-memory fetch sequencer.
// The return stack is compiled in only when RET_STACK_EN is defined.
package prog_seq_pkg;

  localparam int PROG_AW          = 10;
  localparam int PROG_DW          = 16;
  localparam int PROG_STACK_DEPTH = 8;

  typedef logic [PROG_AW-1:0] paddr_t;
  typedef logic [PROG_DW-1:0] pinstr_t;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses for call/ret; only the pointer is reset,
// entry contents are don't-care after reset.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   ptr;
  logic [PW-1:0] top_idx;
  logic [W-1:0]  mem [DEPTH];

  assign full    = (ptr == (PW+1)'(DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr[PW-1:0] - PW'(1);
  assign top     = mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch sequencer: owns the pc, fills the instruction register and handles
// jump/call/ret/halt. Define RET_STACK_EN to build in the hardware return stack.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int AW          = PROG_AW,
  parameter int DW          = PROG_DW,
  parameter int STACK_DEPTH = PROG_STACK_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_addr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] jump_addr,
  input  logic          halt,
  output logic          stk_ovf,
  output logic          stk_unf,
  output logic          faulted
);

  seq_state_t    state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [DW-1:0] instr_p0, instr_p0_nxt;
  logic [AW-1:0] instr_addr_p0, instr_addr_p0_nxt;
  logic          vld_p0, vld_p0_nxt;
  logic          ovf, ovf_nxt, unf, unf_nxt;

  logic          consume;
  logic          jump_sel, call_sel, ret_sel;
  logic          push, pop;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_top;

  assign consume = vld_p0 & instr_ready;

`ifdef RET_STACK_EN
  logic [AW-1:0] push_val;

  assign jump_sel = consume & jump;
  assign call_sel = consume & call & ~jump;
  assign ret_sel  = consume & ret & ~jump & ~call;
  // Return to the word after the call; wraps naturally at 2^AW.
  assign push_val = instr_addr_p0 + AW'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (AW)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_val),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  logic unused_stk;

  assign jump_sel   = consume & (jump | call);
  assign call_sel   = 1'b0;
  assign ret_sel    = 1'b0;
  assign stk_full   = 1'b0;
  assign stk_empty  = 1'b1;
  assign stk_top    = '0;
  assign unused_stk = push | pop | ret;
`endif

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    instr_p0_nxt      = instr_p0;
    instr_addr_p0_nxt = instr_addr_p0;
    vld_p0_nxt        = vld_p0;
    ovf_nxt           = ovf;
    unf_nxt           = unf;
    push              = 1'b0;
    pop               = 1'b0;

    case (state)
      ST_BOOT: begin
        instr_p0_nxt      = mem_data;
        instr_addr_p0_nxt = pc;
        pc_nxt            = pc + AW'(1);
        vld_p0_nxt        = 1'b1;
        state_nxt         = ST_RUN;
      end

      ST_RUN: begin
        if (ret_sel && stk_empty) begin
          unf_nxt    = 1'b1;
          vld_p0_nxt = 1'b0;
          state_nxt  = ST_FAULT;
        end else begin
          if (jump_sel) begin
            pc_nxt     = jump_addr;
            vld_p0_nxt = 1'b0;
          end else if (call_sel) begin
            pc_nxt     = jump_addr;
            vld_p0_nxt = 1'b0;
            if (stk_full) ovf_nxt = 1'b1;
            else          push    = 1'b1;
          end else if (ret_sel) begin
            pc_nxt     = stk_top;
            vld_p0_nxt = 1'b0;
            pop        = 1'b1;
          end else if (halt) begin
            // Unconsumed word is refetched after the halt is released.
            if (vld_p0 && !consume) pc_nxt = instr_addr_p0;
            vld_p0_nxt = 1'b0;
          end else if (!vld_p0 || consume) begin
            instr_p0_nxt      = mem_data;
            instr_addr_p0_nxt = pc;
            pc_nxt            = pc + AW'(1);
            vld_p0_nxt        = 1'b1;
          end

          if (halt) begin
            vld_p0_nxt = 1'b0;
            state_nxt  = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        vld_p0_nxt = 1'b0;
        if (!halt) state_nxt = ST_RUN;
      end

      ST_FAULT: begin
        vld_p0_nxt = 1'b0;
      end
    endcase
  end

  // Instruction register stage (p0) and control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_BOOT;
      pc            <= '0;
      instr_p0      <= '0;
      instr_addr_p0 <= '0;
      vld_p0        <= 1'b0;
      ovf           <= 1'b0;
      unf           <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      instr_p0      <= instr_p0_nxt;
      instr_addr_p0 <= instr_addr_p0_nxt;
      vld_p0        <= vld_p0_nxt;
      ovf           <= ovf_nxt;
      unf           <= unf_nxt;
    end
  end

  assign mem_addr    = pc;
  assign instr       = instr_p0;
  assign instr_addr  = instr_addr_p0;
  assign instr_valid = vld_p0;
  assign stk_ovf     = ovf;
  assign stk_unf     = unf;
  assign faulted     = (state == ST_FAULT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer against a Mem[k] = k + 16'h100 program image.
// Covers the RET_STACK_EN build when that macro is defined, call-as-jump otherwise.
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  localparam int AW = PROG_AW;
  localparam int DW = PROG_DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr, instr_addr, jump_addr;
  logic [DW-1:0] mem_data, instr;
  logic          instr_valid, instr_ready;
  logic          jump, call, ret, halt;
  logic          stk_ovf, stk_unf, faulted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_data = DW'(mem_addr) + 16'h0100;

  prog_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .call        (call),
    .ret         (ret),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf),
    .faulted     (faulted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Word at addr is delivered: valid, address and data all as expected.
  task automatic expect_word(input string tag, input int addr);
    check({tag, "_vld"},  32'(instr_valid), 32'd1);
    check({tag, "_addr"}, 32'(instr_addr),  32'(addr));
    check({tag, "_data"}, 32'(instr),       32'(addr + 'h100));
  endtask

  // Redirect via jump or call from the currently valid word, then land on target.
  task automatic redirect(input string tag, input logic is_call, input int target);
    jump      = ~is_call;
    call      = is_call;
    jump_addr = AW'(target);
    step();
    jump = 1'b0;
    call = 1'b0;
    check({tag, "_gap"}, 32'(instr_valid), 32'd0);
    step();
    expect_word(tag, target);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    jump        = 1'b0;
    call        = 1'b0;
    ret         = 1'b0;
    halt        = 1'b0;
    jump_addr   = '0;
    step(2);

    check("rst_vld",   32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_iaddr", 32'(instr_addr),  32'd0);
    check("rst_pc",    32'(mem_addr),    32'd0);
    check("rst_ovf",   32'(stk_ovf),     32'd0);
    check("rst_unf",   32'(stk_unf),     32'd0);
    check("rst_fault", 32'(faulted),     32'd0);

    // Boot fetch happens without ready
    reset = 1'b0;
    step();
    expect_word("boot", 0);
    check("boot_pc", 32'(mem_addr), 32'd1);

    instr_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      expect_word($sformatf("seq%0d", k), k);
    end

    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_word($sformatf("bp%0d", k), 5);
      check($sformatf("bp%0d_pc", k), 32'(mem_addr), 32'd6);
    end
    instr_ready = 1'b1;
    step();
    expect_word("bp_resume", 6);
    step();
    expect_word("bp_next", 7);

    redirect("jmp200", 1'b0, 'h200);
    step();
    expect_word("jmp_next", 'h201);

    redirect("jmp3ff", 1'b0, 'h3FF);
    step();
    expect_word("wrap", 0);

    for (int k = 1; k <= 7; k++) step();
    expect_word("pre_halt", 7);

    // Halt with word 7 unconsumed: rewind and redeliver it
    instr_ready = 1'b0;
    halt        = 1'b1;
    step();
    check("halt_vld", 32'(instr_valid), 32'd0);
    check("halt_pc",  32'(mem_addr),    32'd7);
    step();
    check("halt_hold_vld", 32'(instr_valid), 32'd0);
    halt        = 1'b0;
    instr_ready = 1'b1;
    step();
    check("unhalt_m1_vld", 32'(instr_valid), 32'd0);
    step();
    expect_word("unhalt", 7);
    step();
    expect_word("unhalt_next", 8);

`ifdef RET_STACK_EN
    redirect("to10", 1'b0, 10);
    redirect("call100", 1'b1, 100);
    step();
    expect_word("at101", 101);
    redirect("call300", 1'b1, 300);

    ret = 1'b1;
    step();
    ret = 1'b0;
    check("ret1_gap", 32'(instr_valid), 32'd0);
    step();
    expect_word("ret1", 102);

    ret = 1'b1;
    step();
    ret = 1'b0;
    check("ret2_gap", 32'(instr_valid), 32'd0);
    step();
    expect_word("ret2", 11);
    check("nest_ovf", 32'(stk_ovf), 32'd0);
    check("nest_unf", 32'(stk_unf), 32'd0);

    for (int i = 0; i < 8; i++) redirect($sformatf("deep%0d", i), 1'b1, 'h40 + i * 'h10);
    check("full_ovf", 32'(stk_ovf), 32'd0);
    redirect("deep8", 1'b1, 'h2A0);
    check("ovf_set", 32'(stk_ovf), 32'd1);

    reset = 1'b1;
    step();
    check("rst2_ovf", 32'(stk_ovf),     32'd0);
    check("rst2_vld", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    step();
    expect_word("boot2", 0);

    // Ret on empty stack is fatal until reset
    ret = 1'b1;
    step();
    ret = 1'b0;
    check("unf_set",   32'(stk_unf),     32'd1);
    check("unf_fault", 32'(faulted),     32'd1);
    check("unf_vld",   32'(instr_valid), 32'd0);
    step(3);
    check("fault_vld",  32'(instr_valid), 32'd0);
    check("fault_hold", 32'(faulted),     32'd1);
    check("fault_pc",   32'(mem_addr),    32'd1);
    reset = 1'b1;
    step();
    check("rst3_fault", 32'(faulted), 32'd0);
    check("rst3_unf",   32'(stk_unf), 32'd0);
    reset = 1'b0;
`else
    redirect("calljmp", 1'b1, 100);
    ret = 1'b1;
    step();
    ret = 1'b0;
    expect_word("ret_ignored", 101);
    for (int i = 0; i < 9; i++) redirect($sformatf("deep%0d", i), 1'b1, 'h40 + i * 'h10);
    check("nostk_ovf",   32'(stk_ovf), 32'd0);
    check("nostk_unf",   32'(stk_unf), 32'd0);
    check("nostk_fault", 32'(faulted), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
